// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter register and instruction-fetch sequencer for
// the unpipelined core. Fetches one instruction at a time over a req/ack
// handshake, holds it for decode until the datapath retires it, then computes
// the next PC (pc+4, pc+imm, or the jalr target) and starts the next fetch.
// Misaligned next-PC values and unanswered fetches park the unit in FAULT
// until reset.

module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    // Branch / jump resolution from the datapath
    input  logic        PC_src,
    input  logic        jalr,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        instr_done,

    // Instruction memory handshake
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,

    // Decode-facing view of the current instruction
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,

    // Sticky fault flags
    output logic        misalign_fault,
    output logic        fetch_timeout
);

    // The timeout counter only has to reach IMEM_TIMEOUT-1, so clog2 bits
    // suffice; a single-cycle timeout still needs one bit to exist.
    localparam int unsigned CNT_W = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      next_pc;
    logic             next_misaligned;

    // The fetch address is the PC itself; it is stable for the whole FETCH
    // state because pc only moves on the EXEC -> FETCH transition.
    assign imem_addr = pc;

    // Link value for jal/jalr, valid in every state.
    assign pc_plus4 = pc + 32'd4;

    // Next-PC selection: jalr overrides PC_src; all sums wrap modulo 2^32.
    always_comb begin
        // NOTE: assigning a default before any condition keeps every path
        // driven, so no latch is inferred for next_pc.
        next_pc = pc_plus4;
        if (jalr) begin
            next_pc = (rs1 + imm) & 32'hFFFF_FFFE;
        end else if (PC_src) begin
            next_pc = pc + imm;
        end
    end

    // A jalr target has bit 0 cleared but bit 1 may still be set, so the
    // alignment test covers both low bits for every source.
    assign next_misaligned = (next_pc[1:0] != 2'b00);

    // Fetch sequencer: state, PC, latched instruction and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register in this block samples the pre-edge values of the others.
            state          <= IDLE;
            pc             <= RESET_VECTOR;
            imem_req       <= 1'b0;
            instr          <= 32'h0000_0000;
            instr_valid    <= 1'b0;
            misalign_fault <= 1'b0;
            fetch_timeout  <= 1'b0;
            wait_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Any ack seen here is stale (e.g. from an aborted fetch).
                    imem_req <= 1'b1;
                    wait_cnt <= '0;
                    state    <= FETCH;
                end

                FETCH: begin
                    if (imem_ack) begin
                        // An ack on the final allowed cycle still wins.
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= EXEC;
                    end else if (wait_cnt == CNT_LAST) begin
                        fetch_timeout <= 1'b1;
                        imem_req      <= 1'b0;
                        state         <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                EXEC: begin
                    // imem_ack is ignored here: no request is outstanding.
                    if (instr_done) begin
                        instr_valid <= 1'b0;
                        if (next_misaligned) begin
                            // pc is left pointing at the faulting instruction.
                            misalign_fault <= 1'b1;
                            imem_req       <= 1'b0;
                            state          <= FAULT;
                        end else begin
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            wait_cnt <= '0;
                            state    <= FETCH;
                        end
                    end
                end

                FAULT: begin
                    // Terminal until reset; everything is frozen.
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end

                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit. Inputs change 1 ns after each rising
// edge and outputs are sampled at the same point, well away from the edge.
// The DUT is built with IMEM_TIMEOUT=4 so the timeout boundary is reachable.

module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        PC_src;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        instr_done;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misalign_fault;
    logic        fetch_timeout;

    int checks   = 0;
    int failures = 0;

    pc_fetch_unit #(
        .RESET_VECTOR (32'h0000_0000),
        .IMEM_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PC_src         (PC_src),
        .jalr           (jalr),
        .imm            (imm),
        .rs1            (rs1),
        .instr_done     (instr_done),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .misalign_fault (misalign_fault),
        .fetch_timeout  (fetch_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the first cycle a request is visible; ack is driven in the
    // (lat+1)-th FETCH cycle. Leaves the bench in the first EXEC cycle.
    task automatic do_fetch(input string tag, input logic [31:0] addr,
                            input logic [31:0] word, input int lat);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"}, imem_addr, addr);
        repeat (lat) tick();
        check({tag, "_nvalid"}, {31'd0, instr_valid}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        check({tag, "_instr"}, instr, word);
        check({tag, "_reqdrop"}, {31'd0, imem_req}, 32'd0);
    endtask

    // One-cycle instr_done pulse carrying the branch decision.
    task automatic retire(input logic j, input logic s, input logic [31:0] i, input logic [31:0] r);
        jalr       = j;
        PC_src     = s;
        imm        = i;
        rs1        = r;
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        jalr       = 1'b0;
        PC_src     = 1'b0;
        imm        = 32'h0;
        rs1        = 32'h0;
    endtask

    initial begin
        rst        = 1'b1;
        PC_src     = 1'b0;
        jalr       = 1'b0;
        imm        = 32'h0;
        rs1        = 32'h0;
        instr_done = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;

        // Reset state, visible before any clock edge.
        #2;
        check("rst_pc", pc, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_mis", {31'd0, misalign_fault}, 32'd0);
        check("rst_tmo", {31'd0, fetch_timeout}, 32'd0);
        check("rst_pc4", pc_plus4, 32'h4);

        tick();
        rst = 1'b0;
        tick();

        // Sequential fetch, ack two cycles after each request.
        do_fetch("f0", 32'h0, 32'h0000_0013, 2);
        retire(1'b0, 1'b0, 32'h0, 32'h0);
        check("seq_req_next", {31'd0, imem_req}, 32'd1);
        do_fetch("f4", 32'h4, 32'h0010_0093, 2);
        retire(1'b0, 1'b0, 32'h0, 32'h0);

        // instr_done during FETCH must not move pc.
        check("f8_pc", pc, 32'h8);
        PC_src     = 1'b1;
        imm        = 32'h100;
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        PC_src     = 1'b0;
        imm        = 32'h0;
        check("done_in_fetch_pc", pc, 32'h8);
        do_fetch("f8", 32'h8, 32'h0020_0113, 1);

        // Stray ack during EXEC must not replace the instruction.
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("ack_in_exec_instr", instr, 32'h0020_0113);
        check("ack_in_exec_valid", {31'd0, instr_valid}, 32'd1);
        check("ack_in_exec_req", {31'd0, imem_req}, 32'd0);

        // Taken branch 0x8 + 0xF8 -> 0x100, then negative offset -> 0xF0.
        retire(1'b0, 1'b1, 32'h0000_00F8, 32'h0);
        do_fetch("f100", 32'h100, 32'h1111_1111, 1);
        retire(1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0);
        do_fetch("fF0", 32'hF0, 32'h2222_2222, 1);

        // 0xF0 + 0xFFFFFF0C -> 0xFFFFFFFC, then pc+4 wraps to 0.
        retire(1'b0, 1'b1, 32'hFFFF_FF0C, 32'h0);
        check("top_pc4_wrap", pc_plus4, 32'h0);
        do_fetch("fFFC", 32'hFFFF_FFFC, 32'h3333_3333, 1);
        retire(1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch("fwrap", 32'h0, 32'h4444_4444, 1);

        // jalr beats PC_src, bit 0 cleared: 0x201+3 -> 0x204.
        // Ack on the last allowed FETCH cycle still wins.
        retire(1'b1, 1'b1, 32'h3, 32'h201);
        do_fetch("f204", 32'h204, 32'h5555_5555, 3);
        check("f204_tmo", {31'd0, fetch_timeout}, 32'd0);

        // jalr to 0x202 is misaligned: fault, pc frozen, no more requests.
        retire(1'b1, 1'b0, 32'h0, 32'h202);
        check("mis_flag", {31'd0, misalign_fault}, 32'd1);
        check("mis_pc", pc, 32'h204);
        check("mis_valid", {31'd0, instr_valid}, 32'd0);
        repeat (3) tick();
        check("mis_req_after", {31'd0, imem_req}, 32'd0);
        check("mis_pc_after", pc, 32'h204);

        // Reset out of FAULT, then reset again in the middle of a fetch.
        rst = 1'b1;
        #1;
        check("rst2_mis", {31'd0, misalign_fault}, 32'd0);
        check("rst2_pc", pc, 32'h0);
        check("rst2_instr", instr, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        do_fetch("r0", 32'h0, 32'h6666_6666, 1);
        retire(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        check("mid_fetch_addr", imem_addr, 32'h4);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc", pc, 32'h0);
        check("async_rst_req", {31'd0, imem_req}, 32'd0);
        tick();
        rst = 1'b0;
        // Late ack while IDLE, before the new request appears.
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("late_ack_instr", instr, 32'h0);
        do_fetch("restart", 32'h0, 32'h7777_7777, 1);

        // Fetch timeout: four FETCH cycles without ack.
        retire(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        check("tmo_before", {31'd0, fetch_timeout}, 32'd0);
        check("tmo_req_before", {31'd0, imem_req}, 32'd1);
        tick();
        check("tmo_flag", {31'd0, fetch_timeout}, 32'd1);
        check("tmo_req", {31'd0, imem_req}, 32'd0);
        check("tmo_mis", {31'd0, misalign_fault}, 32'd0);
        // Ack after the fault is ignored.
        imem_ack   = 1'b1;
        imem_rdata = 32'h8888_8888;
        repeat (2) tick();
        imem_ack   = 1'b0;
        check("tmo_pc_frozen", pc, 32'h4);
        check("tmo_valid", {31'd0, instr_valid}, 32'd0);
        check("tmo_instr", instr, 32'h7777_7777);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
